char_scroller: RTL and testbench
================================

CHAR_SCROLLER -- requirements
Module: char_scroller

Interface
REQ-001 SHALL have parameter GAP_COLS, default 1: number of blank spacer columns emitted after each glyph (0..3).
REQ-002 SHALL have parameter IDLE_BLANK, default 1: when 1, emit a blank column on each step while idle.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port char_valid  input  1  upstream character available.
REQ-006 SHALL have port char_data  input  8  upstream character code.
REQ-007 SHALL have port char_ready  output  1  block accepts a character this cycle.
REQ-008 SHALL have port rom_addr  output  7  registered glyph address to the font ROM.
REQ-009 SHALL have port rom_data  input  35  combinational 5x7 glyph bitmap returned for rom_addr.
REQ-010 SHALL have port step  input  1  scroll tick, one-cycle pulse.
REQ-011 SHALL have port col_valid  output  1  one-cycle pulse: col_data is a new display column.
REQ-012 SHALL have port col_data  output  7  column pixels, bit 6 = top row.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, SHIFT, GAP.
REQ-015 SHALL drive char_ready = (state == IDLE), combinationally.
REQ-016 In IDLE, on char_valid && char_ready: SHALL load rom_addr = char_data[6:0], or 7'h7F if char_data[7] = 1, and go to FETCH.
REQ-017 In FETCH (exactly one cycle): SHALL latch rom_data into a 35-bit bitmap register, clear col_idx to 0, and go to SHIFT.
REQ-018 Column c (0 = leftmost) SHALL be bitmap[34-7c : 28-7c].
REQ-019 In SHIFT, on step: SHALL register col_data = column col_idx and col_valid = 1 on the next edge, then increment col_idx.
REQ-020 After column 4 is emitted: SHALL go to GAP if GAP_COLS > 0, else to IDLE.
REQ-021 In GAP, on step: SHALL emit col_data = 0 with col_valid = 1, count the gap column, and go to IDLE after GAP_COLS gap columns.
REQ-022 In IDLE, on step: SHALL emit col_data = 0 with col_valid = 1 if IDLE_BLANK = 1, else emit nothing.
REQ-023 On a simultaneous step and character accept in IDLE: SHALL do both; the step is consumed by the idle rule (REQ-022).
REQ-024 On step during FETCH: SHALL set a one-deep pending flag and service it in the first SHIFT cycle as if step were asserted.
REQ-025 SHALL drop any further step pulses while pending is already set.
REQ-026 col_valid SHALL be low in every cycle not covered by REQ-019, REQ-021, REQ-022 and REQ-024.
REQ-027 col_data SHALL hold its last value when col_valid is low.
REQ-028 Latency SHALL be: step sampled at edge N -> col_valid high for the cycle after edge N.
REQ-029 Latency SHALL be: accept at edge N -> first glyph column available on the first step sampled at or after edge N+2, or from a pending step.
REQ-030 Per glyph, SHALL emit exactly 5 + GAP_COLS columns, with no loss or duplication.

Reset
REQ-031 While rst_n = 0: state = IDLE, rom_addr = 0, bitmap = 0, col_idx = 0, gap count = 0, pending = 0, col_valid = 0, col_data = 0, busy = 0.
REQ-032 char_ready SHALL be 1 during reset and after release, because state is IDLE.
REQ-033 Reset asserted mid-glyph SHALL abandon the glyph; no further columns of it are emitted after release.

Structure
REQ-034 Shared package charmatrix_pkg SHALL hold FONT_COLS = 5, FONT_ROWS = 7, GLYPH_BITS = 35, the FSM state enum, and the fallback address 7'h7F.
REQ-035 There SHALL be no sub-module; the font ROM is instantiated by the parent and connected through rom_addr and rom_data.
REQ-036 Column selection SHALL be a local function or indexed part-select.

Verification
REQ-037 Bench SHALL check: stub ROM returns {7'h01,7'h02,7'h04,7'h08,7'h10}; send 0x41, then 6 steps -> col_data sequence 01, 02, 04, 08, 10, 00, then IDLE with busy = 0.
REQ-038 Bench SHALL check: char_data = 0xC1 -> rom_addr = 7'h7F.
REQ-039 Bench SHALL check: step in the same cycle as accept with IDLE_BLANK = 1 -> one 00 column, then the glyph columns follow on later steps.
REQ-040 Bench SHALL check: step asserted during FETCH -> column 0 emitted without a further step.
REQ-041 Bench SHALL check: two back-to-back characters with GAP_COLS = 0 -> 10 columns, char_ready high for exactly one cycle between glyphs.
REQ-042 Bench SHALL check: rst_n pulsed low after column 2 -> col_valid = 0 and char_ready = 1 immediately, and idle-only behaviour after release.

Source files
------------

// File: rtl/charmatrix_pkg.sv
// Shared definitions for the character-matrix display path.
//   FONT_COLS / FONT_ROWS / GLYPH_BITS : 5x7 glyph geometry
//   FALLBACK_ADDR                      : glyph used for codes with bit 7 set
//   state_e                            : scroller FSM states
package charmatrix_pkg;

  localparam int FONT_COLS  = 5;
  localparam int FONT_ROWS  = 7;
  localparam int GLYPH_BITS = 35;

  localparam logic [6:0] FALLBACK_ADDR = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/char_scroller.sv
// Character scroller: accepts one character at a time, fetches its 5x7
// bitmap from an external combinational font ROM, and emits the glyph one
// column per scroll step, followed by GAP_COLS blank spacer columns.
//
// Parameters
//   GAP_COLS   : blank columns after each glyph (0..3)
//   IDLE_BLANK : 1 = emit a blank column on each step while idle
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   char_valid : upstream character available
//   char_data  : upstream character code
//   char_ready : high while idle (a character is accepted this cycle)
//   rom_addr   : registered glyph address to the font ROM
//   rom_data   : 35-bit glyph bitmap for rom_addr (column 0 in the MSBs)
//   step       : one-cycle scroll tick
//   col_valid  : one-cycle pulse marking a new column on col_data
//   col_data   : column pixels, bit 6 = top row; holds when col_valid low
//   busy       : high whenever the FSM is not idle
module char_scroller
  import charmatrix_pkg::*;
#(
  parameter int GAP_COLS   = 1,
  parameter int IDLE_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  char_valid,
  input  logic [7:0]            char_data,
  output logic                  char_ready,
  output logic [6:0]            rom_addr,
  input  logic [GLYPH_BITS-1:0] rom_data,
  input  logic                  step,
  output logic                  col_valid,
  output logic [FONT_ROWS-1:0]  col_data,
  output logic                  busy
);

  state_e                state;
  logic [GLYPH_BITS-1:0] bitmap;
  logic [2:0]            col_idx;
  logic [1:0]            gap_cnt;
  logic                  pending;

  // Column c occupies bitmap[34-7c : 28-7c]; column 0 is the leftmost.
  function automatic logic [FONT_ROWS-1:0] col_sel(input logic [GLYPH_BITS-1:0] bm,
                                                   input logic [2:0] idx);
    logic [FONT_ROWS-1:0] c;
    case (idx)
      3'd0:    c = bm[34:28];
      3'd1:    c = bm[27:21];
      3'd2:    c = bm[20:14];
      3'd3:    c = bm[13:7];
      default: c = bm[6:0];
    endcase
    return c;
  endfunction

  assign char_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rom_addr  <= '0;
      bitmap    <= '0;
      col_idx   <= '0;
      gap_cnt   <= '0;
      pending   <= 1'b0;
      col_valid <= 1'b0;
      col_data  <= '0;
    end else begin
      col_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // An idle step is always consumed here, even when a character
          // is accepted on the same edge.
          if (step && (IDLE_BLANK != 0)) begin
            col_valid <= 1'b1;
            col_data  <= '0;
          end
          if (char_valid) begin
            rom_addr <= char_data[7] ? FALLBACK_ADDR : char_data[6:0];
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // rom_addr was registered on the previous edge, so rom_data is
          // valid now. A step arriving here is remembered for SHIFT.
          bitmap  <= rom_data;
          col_idx <= '0;
          if (step) pending <= 1'b1;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // A pending step and a live step in the same cycle yield one
          // column; the live one is dropped.
          if (step || pending) begin
            col_valid <= 1'b1;
            col_data  <= col_sel(bitmap, col_idx);
            pending   <= 1'b0;
            if (col_idx == 3'(FONT_COLS - 1)) begin
              col_idx <= '0;
              gap_cnt <= '0;
              state   <= (GAP_COLS > 0) ? ST_GAP : ST_IDLE;
            end else begin
              col_idx <= col_idx + 3'd1;
            end
          end
        end
        ST_GAP: begin
          if (step) begin
            col_valid <= 1'b1;
            col_data  <= '0;
            if (gap_cnt == 2'(GAP_COLS - 1)) begin
              gap_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 2'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_scroller.sv
// Bench for char_scroller: a default instance (GAP_COLS=1, IDLE_BLANK=1)
// driven from a per-cycle vector table, and a GAP_COLS=0 / IDLE_BLANK=0
// instance for back-to-back glyphs. Both see a stub ROM returning a fixed
// bitmap whose columns are 01,02,04,08,10.
module tb_char_scroller;

  localparam logic [34:0] ROM_PAT = {7'h01, 7'h02, 7'h04, 7'h08, 7'h10};

  logic        clk;
  logic        rst_n;

  logic        cv_a, st_a, rdy_a, colv_a, busy_a;
  logic [7:0]  cd_a;
  logic [6:0]  addr_a, col_a;
  logic [34:0] rom_a;

  logic        cv_b, st_b, rdy_b, colv_b, busy_b;
  logic [7:0]  cd_b;
  logic [6:0]  addr_b, col_b;
  logic [34:0] rom_b;

  int checks   = 0;
  int failures = 0;

  assign rom_a = ROM_PAT;
  assign rom_b = ROM_PAT;

  char_scroller #(.GAP_COLS(1), .IDLE_BLANK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .char_valid(cv_a), .char_data(cd_a),
    .char_ready(rdy_a), .rom_addr(addr_a), .rom_data(rom_a), .step(st_a),
    .col_valid(colv_a), .col_data(col_a), .busy(busy_a)
  );

  char_scroller #(.GAP_COLS(0), .IDLE_BLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .char_valid(cv_b), .char_data(cd_b),
    .char_ready(rdy_b), .rom_addr(addr_b), .rom_data(rom_b), .step(st_b),
    .col_valid(colv_b), .col_data(col_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [7:0] cd;
    logic       st;
    logic       ev;   // expected col_valid after the edge
    logic [6:0] ed;   // expected col_data
    logic       er;   // expected char_ready
    logic       eb;   // expected busy
    logic [6:0] ea;   // expected rom_addr
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic cv, input logic [7:0] cd, input logic st,
                     input logic ev, input logic [6:0] ed, input logic er,
                     input logic eb, input logic [6:0] ea);
    vec_t v;
    v.cv = cv; v.cd = cd; v.st = st; v.ev = ev;
    v.ed = ed; v.er = er; v.eb = eb; v.ea = ea;
    vq.push_back(v);
  endtask

  initial begin
    logic [6:0] seq [10];
    int ncol, accepts, rdy_cycles, spurious;

    //     cv  cd     st ev  ed     er eb ea
    // glyph 0x41, columns then one gap, then idle blanks
    add(1, 8'h41, 0, 0, 7'h00, 0, 1, 7'h41);
    add(0, 8'h00, 0, 0, 7'h00, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h01, 0, 1, 7'h41);
    add(0, 8'h00, 0, 0, 7'h01, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h02, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h04, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h08, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h10, 0, 1, 7'h41);
    add(0, 8'h00, 0, 0, 7'h10, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h00, 1, 0, 7'h41);
    add(0, 8'h00, 1, 1, 7'h00, 1, 0, 7'h41);
    add(0, 8'h00, 0, 0, 7'h00, 1, 0, 7'h41);
    // code 0xC1 -> fallback address; step during FETCH becomes pending
    add(1, 8'hC1, 0, 0, 7'h00, 0, 1, 7'h7F);
    add(0, 8'h00, 1, 0, 7'h00, 0, 1, 7'h7F);
    add(0, 8'h00, 0, 1, 7'h01, 0, 1, 7'h7F);
    add(0, 8'h00, 1, 1, 7'h02, 0, 1, 7'h7F);
    add(0, 8'h00, 1, 1, 7'h04, 0, 1, 7'h7F);
    add(0, 8'h00, 1, 1, 7'h08, 0, 1, 7'h7F);
    add(0, 8'h00, 1, 1, 7'h10, 0, 1, 7'h7F);
    add(0, 8'h00, 1, 1, 7'h00, 1, 0, 7'h7F);
    // step together with accept: idle blank, no pending, glyph later
    add(1, 8'h41, 1, 1, 7'h00, 0, 1, 7'h41);
    add(0, 8'h00, 0, 0, 7'h00, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h01, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h02, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h04, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h08, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h10, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h00, 1, 0, 7'h41);
    // pending set, then a live step in the first SHIFT cycle is dropped
    add(1, 8'h41, 0, 0, 7'h00, 0, 1, 7'h41);
    add(0, 8'h00, 1, 0, 7'h00, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h01, 0, 1, 7'h41);
    add(0, 8'h00, 0, 0, 7'h01, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h02, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h04, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h08, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h10, 0, 1, 7'h41);
    add(0, 8'h00, 1, 1, 7'h00, 1, 0, 7'h41);

    cv_a = 0; cd_a = 0; st_a = 0;
    cv_b = 0; cd_b = 0; st_b = 0;
    rst_n = 0;
    #2;
    chk("reset_col_valid", 32'(colv_a), 32'd0);
    chk("reset_col_data",  32'(col_a),  32'd0);
    chk("reset_rom_addr",  32'(addr_a), 32'd0);
    chk("reset_ready",     32'(rdy_a),  32'd1);
    chk("reset_busy",      32'(busy_a), 32'd0);
    chk("reset_ready_b",   32'(rdy_b),  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // table-driven section on dut_a
    foreach (vq[i]) begin
      cv_a = vq[i].cv; cd_a = vq[i].cd; st_a = vq[i].st;
      @(posedge clk); #1;
      chk($sformatf("v%0d_col_valid", i), 32'(colv_a), 32'(vq[i].ev));
      chk($sformatf("v%0d_col_data",  i), 32'(col_a),  32'(vq[i].ed));
      chk($sformatf("v%0d_ready",     i), 32'(rdy_a),  32'(vq[i].er));
      chk($sformatf("v%0d_busy",      i), 32'(busy_a), 32'(vq[i].eb));
      chk($sformatf("v%0d_rom_addr",  i), 32'(addr_a), 32'(vq[i].ea));
      @(negedge clk);
    end
    cv_a = 0; st_a = 0;

    // back-to-back glyphs on dut_b with step held high
    seq = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h01, 7'h02, 7'h04, 7'h08, 7'h10};
    ncol = 0; accepts = 0; rdy_cycles = 0;
    cd_b = 8'h41; st_b = 1;
    for (int cyc = 0; cyc < 40 && ncol < 10; cyc++) begin
      if (colv_b) begin
        chk($sformatf("b2b_col%0d", ncol), 32'(col_b), 32'(seq[ncol]));
        ncol++;
      end
      if (rdy_b && accepts == 1) rdy_cycles++;
      cv_b = (accepts < 2);
      if (cv_b && rdy_b) accepts++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (colv_b && ncol < 10) begin
      chk($sformatf("b2b_col%0d", ncol), 32'(col_b), 32'(seq[ncol]));
      ncol++;
    end
    cv_b = 0;
    chk("b2b_column_count", 32'(ncol), 32'd10);
    chk("b2b_ready_between", 32'(rdy_cycles), 32'd1);
    // idle with IDLE_BLANK=0: steps produce nothing
    spurious = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (colv_b) spurious++;
      @(negedge clk);
    end
    chk("b2b_idle_no_blank", 32'(spurious), 32'd0);
    chk("b2b_idle_busy", 32'(busy_b), 32'd0);
    st_b = 0;

    // reset mid-glyph on dut_a
    cv_a = 1; cd_a = 8'h41; st_a = 0;
    @(negedge clk);
    cv_a = 0;
    @(negedge clk);
    st_a = 1;
    repeat (3) @(negedge clk);
    st_a = 0;
    chk("mid_col2_data", 32'(col_a), 32'h04);
    chk("mid_busy", 32'(busy_a), 32'd1);
    rst_n = 0;
    #1;
    chk("rst_col_valid", 32'(colv_a), 32'd0);
    chk("rst_ready",     32'(rdy_a),  32'd1);
    chk("rst_busy",      32'(busy_a), 32'd0);
    chk("rst_col_data",  32'(col_a),  32'd0);
    @(negedge clk);
    rst_n = 1;
    st_a = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d_valid", k), 32'(colv_a), 32'd1);
      chk($sformatf("post_rst%0d_data",  k), 32'(col_a),  32'd0);
      chk($sformatf("post_rst%0d_busy",  k), 32'(busy_a), 32'd0);
      @(negedge clk);
    end
    st_a = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
